// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
// Illegal control codes complete normally but report rsp_err with a zeroed result.

module alu #(
    parameter int REG_WIDTH = 32
) (
    input  logic [REG_WIDTH-1:0] in1_i,
    input  logic [REG_WIDTH-1:0] in2_i,
    input  logic [3:0]           ctrl_i,
    output logic [REG_WIDTH-1:0] result_o
);
    // Shift amounts use the full in2 value; counts >= REG_WIDTH shift everything out.
    always_comb begin
        result_o = '0;
        case (ctrl_i)
            4'b0000: result_o = in1_i & in2_i;
            4'b0001: result_o = in1_i | in2_i;
            4'b0010: result_o = in1_i + in2_i;
            4'b0011: result_o = in1_i ^ in2_i;
            4'b0110: result_o = in1_i - in2_i;
            4'b0111: result_o = in1_i << in2_i;
            4'b1000: result_o = in1_i >> in2_i;
            4'b1001: result_o = in1_i >> in2_i;
            default: result_o = '0;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [REG_WIDTH-1:0] req0_in1,
    input  logic [REG_WIDTH-1:0] req0_in2,
    input  logic [3:0]           req0_ctrl,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [REG_WIDTH-1:0] req1_in1,
    input  logic [REG_WIDTH-1:0] req1_in2,
    input  logic [3:0]           req1_ctrl,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REG_WIDTH-1:0] rsp_result,
    output logic                 rsp_id,
    output logic                 rsp_err,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e                 state_q, state_d;
    logic                   rr_ptr_q, rr_ptr_d;
    logic [REG_WIDTH-1:0]   op_in1_q, op_in1_d;
    logic [REG_WIDTH-1:0]   op_in2_q, op_in2_d;
    logic [3:0]             op_ctrl_q, op_ctrl_d;
    logic                   op_id_q, op_id_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [REG_WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                   rsp_id_q, rsp_id_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   grant0, grant1;
    logic                   ctrl_legal;
    logic [REG_WIDTH-1:0]   alu_result;

    alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
        .in1_i    (op_in1_q),
        .in2_i    (op_in2_q),
        .ctrl_i   (op_ctrl_q),
        .result_o (alu_result)
    );

    always_comb begin
        ctrl_legal = 1'b0;
        case (op_ctrl_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0110, 4'b0111, 4'b1000, 4'b1001: ctrl_legal = 1'b1;
            default:                            ctrl_legal = 1'b0;
        endcase
    end

    // rr_ptr only matters when both requesters are valid.
    assign grant0 = req0_valid & (~req1_valid | ~rr_ptr_q);
    assign grant1 = req1_valid & (~req0_valid |  rr_ptr_q);

    assign req0_ready = (state_q == IDLE) & grant0 & ~reset;
    assign req1_ready = (state_q == IDLE) & grant1 & ~reset;
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_in1_d     = op_in1_q;
        op_in2_d     = op_in2_q;
        op_ctrl_d    = op_ctrl_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_id_d   = grant1;
                    op_in1_d  = grant1 ? req1_in1  : req0_in1;
                    op_in2_d  = grant1 ? req1_in2  : req0_in2;
                    op_ctrl_d = grant1 ? req1_ctrl : req0_ctrl;
                    rr_ptr_d  = ~grant1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = ctrl_legal ? alu_result : '0;
                rsp_id_d     = op_id_q;
                rsp_err_d    = ~ctrl_legal;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            op_in1_q     <= '0;
            op_in2_q     <= '0;
            op_ctrl_q    <= '0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_in1_q     <= op_in1_d;
            op_in2_q     <= op_in2_d;
            op_ctrl_q    <= op_ctrl_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;

    typedef struct {
        logic        id;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  ctrl;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        id;
        logic        err;
    } exp_t;

    vec_t vecs[14];
    exp_t sbq[$];

    alu_share_arbiter #(.REG_WIDTH(32)) dut (
        .clk(clk), .reset(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input logic id, input logic err);
        exp_t e;
        e.res = res;
        e.id  = id;
        e.err = err;
        sbq.push_back(e);
    endtask

    // Response monitor: every handshake must match the oldest accepted op.
    initial forever begin
        @(negedge clk);
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected response", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            hs_count++;
        end
    end

    task automatic do_op(input vec_t v, input string nm);
        logic got;
        @(posedge clk); #1;
        if (v.id) begin
            req1_valid = 1'b1; req1_in1 = v.in1; req1_in2 = v.in2; req1_ctrl = v.ctrl;
        end else begin
            req0_valid = 1'b1; req0_in1 = v.in1; req0_in2 = v.in2; req0_ctrl = v.ctrl;
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = v.id ? req1_ready : req0_ready;
        end
        chk({nm, " accept"}, 32'(got), 32'd1);
        if (got) push_exp(v.exp_res, v.id, v.exp_err);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (got) begin
            @(negedge clk);
            chk({nm, " exec busy"}, 32'(busy), 32'd1);
            chk({nm, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk({nm, " rsp_valid at N+2"}, 32'(rsp_valid), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    // Both requesters held valid; checks alternation, spacing, and one-in-flight.
    task automatic run_both(input int nops, input logic first_id, input string nm);
        int grants;
        int last_cyc;
        int hs0;
        logic exp_id;
        logic gid;
        grants   = 0;
        last_cyc = -1;
        hs0      = hs_count;
        exp_id   = first_id;
        @(posedge clk); #1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_in1 = 32'h0000F0F0; req0_in2 = 32'h0000FF00; req0_ctrl = 4'b0000;
        req1_valid = 1'b1; req1_in1 = 32'd10;       req1_in2 = 32'd3;        req1_ctrl = 4'b0110;
        for (int b = 0; b < 60 && grants < nops; b++) begin
            @(negedge clk);
            chk({nm, " one-hot ready"}, 32'(req0_ready & req1_ready), 32'd0);
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
                chk({nm, " grant order"}, 32'(gid), 32'(exp_id));
                chk({nm, " prior responses done"}, 32'(hs_count - hs0), 32'(grants));
                if (last_cyc >= 0) chk({nm, " grant spacing"}, 32'(cyc - last_cyc), 32'd3);
                if (gid) push_exp(32'd7, 1'b1, 1'b0);
                else     push_exp(32'h0000F000, 1'b0, 1'b0);
                last_cyc = cyc;
                exp_id   = ~exp_id;
                grants++;
            end
        end
        chk({nm, " grant count"}, 32'(grants), 32'(nops));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int b = 0; b < 20 && (sbq.size() != 0 || busy); b++) @(negedge clk);
        chk({nm, " drained"}, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFFF,   32'd2,          4'b0010, 32'd1,          1'b0};
        vecs[2]  = '{1'b0, 32'd3,          32'd10,         4'b0110, 32'hFFFFFFF9,   1'b0};
        vecs[3]  = '{1'b1, 32'h0000F0F0,   32'h0000FF00,   4'b0000, 32'h0000F000,   1'b0};
        vecs[4]  = '{1'b0, 32'h0000F0F0,   32'h00000F0F,   4'b0001, 32'h0000FFFF,   1'b0};
        vecs[5]  = '{1'b1, 32'hFFFF0000,   32'h0FF00FF0,   4'b0011, 32'hF00F0FF0,   1'b0};
        vecs[6]  = '{1'b0, 32'd1,          32'd4,          4'b0111, 32'd16,         1'b0};
        vecs[7]  = '{1'b1, 32'd1,          32'd32,         4'b0111, 32'd0,          1'b0};
        vecs[8]  = '{1'b0, 32'h80000000,   32'd31,         4'b1000, 32'd1,          1'b0};
        vecs[9]  = '{1'b1, 32'h80000000,   32'd4,          4'b1001, 32'h08000000,   1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'd40,         4'b1001, 32'd0,          1'b0};
        vecs[11] = '{1'b1, 32'd5,          32'd7,          4'b0100, 32'd0,          1'b1};
        vecs[12] = '{1'b0, 32'hFFFFFFFF,   32'd1,          4'b1111, 32'd0,          1'b1};
        vecs[13] = '{1'b1, 32'h12345678,   32'd0,          4'b1000, 32'h12345678,   1'b0};

        rst = 1'b1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_in1 = '0; req0_in2 = '0; req0_ctrl = '0;
        req1_valid = 1'b1; req1_in1 = '0; req1_in2 = '0; req1_ctrl = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rsp_valid",  32'(rsp_valid), 32'd0);
        chk("reset rsp_result", rsp_result,     32'd0);
        chk("reset rsp_id",     32'(rsp_id),    32'd0);
        chk("reset rsp_err",    32'(rsp_err),   32'd0);
        chk("reset busy",       32'(busy),      32'd0);
        chk("reset req0_ready", 32'(req0_ready), 32'd0);
        chk("reset req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        rst = 1'b0;

        run_both(2, 1'b0, "contention");
        run_both(4, 1'b0, "fairness");

        for (int i = 0; i < 14; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: response must hold while the consumer stalls.
        begin
            logic got;
            @(posedge clk); #1;
            rsp_ready  = 1'b0;
            req0_valid = 1'b1; req0_in1 = 32'd1; req0_in2 = 32'd4; req0_ctrl = 4'b0111;
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = req0_ready;
            end
            chk("bp accept", 32'(got), 32'd1);
            if (got) push_exp(32'd16, 1'b0, 1'b0);
            @(posedge clk); #1;
            req1_valid = 1'b1;
            repeat (2) @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                chk("bp rsp_valid",  32'(rsp_valid),  32'd1);
                chk("bp rsp_result", rsp_result,      32'd16);
                chk("bp busy",       32'(busy),       32'd1);
                chk("bp req0_ready", 32'(req0_ready), 32'd0);
                chk("bp req1_ready", 32'(req1_ready), 32'd0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            rsp_ready  = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp done busy", 32'(busy), 32'd0);
            chk("bp drained", 32'(sbq.size()), 32'd0);
        end

        // Reset during EXEC discards the op and restores requester 0 priority.
        begin
            logic got;
            @(posedge clk); #1;
            req0_valid = 1'b1; req0_in1 = 32'd1; req0_in2 = 32'd1; req0_ctrl = 4'b0010;
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = req0_ready;
            end
            chk("rst-exec accept", 32'(got), 32'd1);
            @(posedge clk); #1;
            req0_valid = 1'b0;
            chk("rst-exec in EXEC", 32'(busy), 32'd1);
            rst = 1'b1;
            #1;
            chk("rst-exec busy", 32'(busy), 32'd0);
            chk("rst-exec rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("rst-exec no rsp", 32'(rsp_valid), 32'd0);
            end
            run_both(1, 1'b0, "post-reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
